ntt_stage_ctrl: RTL and testbench
=================================

// Module: ntt_stage_ctrl
// PURPOSE
//  Sequencer for the 8-butterfly NTT core (256 coeffs, 7 stages, len 128..2).
//  Per stage it issues 16 read/butterfly cycles (8 BUs x 16 = 128 butterflies),
//  drives len/start to the zeta ROM, and inserts a hazard gap so the next stage
//  never reads a bank before the BU pipeline has written back.
//  Delayed write-enable/address tags go to the coefficient-bank write port.
//  Sits between the top-level command interface and the ROM_zeta/BU/bank datapath.
// PARAMETERS
//  BU_LAT      4   butterfly read-to-write latency in cycles; legal range 1..15
//  NUM_STAGES  7   number of stages; stage s uses len = 128 >> s
// PORTS
//  clk_i         in   1  clock
//  rst_i         in   1  synchronous reset, active-high
//  start_i       in   1  begin transform; sampled only in IDLE
//  busy_o        out  1  high while state != IDLE
//  done_o        out  1  one-cycle pulse, transform complete
//  len_o         out  8  stage len to ROM (128,64,..,2); 8'd1 when not in RUN
//  zeta_start_o  out  1  pulse on cnt==0 of every stage (ROM counter resync)
//  rd_en_o       out  1  bank read / BU issue valid
//  rd_cnt_o      out  4  issue index within stage, 0..15
//  stage_o       out  3  current stage, 0..NUM_STAGES-1
//  wr_en_o       out  1  bank write valid (rd_en_o delayed BU_LAT cycles)
//  wr_cnt_o      out  4  rd_cnt_o delayed BU_LAT cycles
//  wr_stage_o    out  3  stage_o delayed BU_LAT cycles
// BEHAVIOUR
//  - Reset (sync, highest priority): state=IDLE; busy/done/zeta_start/rd_en/wr_en=0;
//    len_o=8'd1; rd_cnt/stage/wr_cnt/wr_stage=0; whole write pipeline cleared.
//    Reset mid-transform aborts immediately; no further wr_en pulses.
//  - FSM: IDLE -> RUN -> (GAP -> RUN)* -> DRAIN -> DONE -> IDLE.
//  - IDLE: start_i=1 at edge k -> RUN in cycle k+1, stage=0, cnt=0.
//  - RUN: rd_en_o=1, len_o=128>>stage, zeta_start_o=(cnt==0); cnt increments each
//    cycle. At cnt==15: if stage<NUM_STAGES-1 -> GAP, cnt=0, stage+1; else -> DRAIN.
//  - GAP: exactly BU_LAT cycles, rd_en_o=0, len_o=1 (stops ROM). Last write of
//    stage s lands one cycle before first read of stage s+1. Then -> RUN.
//  - DRAIN: exactly BU_LAT cycles, rd_en_o=0, len_o=1; then -> DONE.
//  - DONE: one cycle, done_o=1, busy_o=1; -> IDLE. start_i ignored here.
//  - start_i ignored in every non-IDLE state (no queuing).
//  - Write pipeline: BU_LAT-deep shift register of {rd_en,rd_cnt,stage}, advances
//    every cycle in all states; wr_* are its output tap (registered).
//  - Stage s first RUN cycle = 1 + s*(16+BU_LAT) after the start edge. Total:
//    done_o at cycle 1 + NUM_STAGES*16 + NUM_STAGES*BU_LAT (141 for defaults).
//  - Exactly 16*NUM_STAGES rd_en and wr_en cycles per transform.
//  - len_o computed as 8'd128 >> stage (3-bit shift); no other values legal.
// TESTING
//  1 Defaults, start at cycle 0 -> RUN cycles 1..16 len=128, zeta_start @1,21,
//    41,61,81,101,121; len 64,32,16,8,4,2 per stage; done_o only at cycle 141.
//  2 Count enables over full run -> 112 rd_en, 112 wr_en; wr_en(t)==rd_en(t-4)
//    with matching cnt/stage; no rd_en while any earlier-stage wr_en pending.
//  3 start_i held high cycles 0..150 -> single transform, done @141, second
//    transform starts only at IDLE cycle 142 (RUN from 143).
//  4 rst_i at cycle 50 for 1 cycle -> cycle 51: busy=0, len_o=1, rd_en=0, and
//    wr_en stays 0 afterwards; new start then behaves as scenario 1.
//  5 BU_LAT=1 -> stage starts at 1,18,35,..; done_o at cycle 120.
//  6 ROM_zeta connected: zeta outputs match per-stage golden table each RUN
//    cycle and are 0 during GAP/DRAIN (ROM running cleared by len_o=1).

Source files
------------

// File: rtl/ntt_stage_ctrl.sv
// Stage sequencer for the 8-butterfly NTT core.
// Issues 16 reads per stage, spaces stages by the BU latency, and tags write-back.
module ntt_stage_ctrl #(
  parameter int BU_LAT     = 4,
  parameter int NUM_STAGES = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] len_o,
  output logic       zeta_start_o,
  output logic       rd_en_o,
  output logic [3:0] rd_cnt_o,
  output logic [2:0] stage_o,
  output logic       wr_en_o,
  output logic [3:0] wr_cnt_o,
  output logic [2:0] wr_stage_o
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    GAP,
    DRAIN,
    DONE
  } state_t;

  localparam logic [3:0] WAIT_LAST  = 4'(BU_LAT - 1);
  localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

  state_t     state;
  logic [3:0] wait_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      len_o        <= 8'd1;
      zeta_start_o <= 1'b0;
      rd_en_o      <= 1'b0;
      rd_cnt_o     <= '0;
      stage_o      <= '0;
    end else begin
      zeta_start_o <= 1'b0;
      done_o       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state        <= RUN;
            busy_o       <= 1'b1;
            rd_en_o      <= 1'b1;
            rd_cnt_o     <= '0;
            stage_o      <= '0;
            len_o        <= 8'd128;
            zeta_start_o <= 1'b1;
          end
        end
        RUN: begin
          if (rd_cnt_o == 4'd15) begin
            rd_en_o  <= 1'b0;
            rd_cnt_o <= '0;
            len_o    <= 8'd1;
            wait_cnt <= '0;
            if (stage_o == LAST_STAGE) begin
              state <= DRAIN;
            end else begin
              state   <= GAP;
              stage_o <= stage_o + 3'd1;
            end
          end else begin
            rd_cnt_o <= rd_cnt_o + 4'd1;
          end
        end
        GAP: begin
          // stage_o already points at the upcoming stage
          if (wait_cnt == WAIT_LAST) begin
            state        <= RUN;
            rd_en_o      <= 1'b1;
            len_o        <= 8'd128 >> stage_o;
            zeta_start_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DRAIN: begin
          if (wait_cnt == WAIT_LAST) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  logic [BU_LAT-1:0] pipe_en;
  logic [3:0]        pipe_cnt   [BU_LAT];
  logic [2:0]        pipe_stage [BU_LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_en <= '0;
      for (int i = 0; i < BU_LAT; i++) begin
        pipe_cnt[i]   <= '0;
        pipe_stage[i] <= '0;
      end
    end else begin
      pipe_en[0]    <= rd_en_o;
      pipe_cnt[0]   <= rd_cnt_o;
      pipe_stage[0] <= stage_o;
      for (int i = 1; i < BU_LAT; i++) begin
        pipe_en[i]    <= pipe_en[i-1];
        pipe_cnt[i]   <= pipe_cnt[i-1];
        pipe_stage[i] <= pipe_stage[i-1];
      end
    end
  end

  assign wr_en_o    = pipe_en[BU_LAT-1];
  assign wr_cnt_o   = pipe_cnt[BU_LAT-1];
  assign wr_stage_o = pipe_stage[BU_LAT-1];

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Directed bench for ntt_stage_ctrl: default latency and BU_LAT=1 instances.
// Checks per-cycle schedule, write tags, start hold-off and mid-run reset.
module tb_ntt_stage_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b;
  logic       a_busy, a_done, a_zs, a_rd, a_wr;
  logic [7:0] a_len;
  logic [3:0] a_cnt, a_wcnt;
  logic [2:0] a_stg, a_wstg;
  logic       b_busy, b_done, b_zs, b_rd, b_wr;
  logic [7:0] b_len;
  logic [3:0] b_cnt, b_wcnt;
  logic [2:0] b_stg, b_wstg;

  ntt_stage_ctrl #(.BU_LAT(4), .NUM_STAGES(7)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a),
    .busy_o(a_busy), .done_o(a_done), .len_o(a_len),
    .zeta_start_o(a_zs), .rd_en_o(a_rd), .rd_cnt_o(a_cnt),
    .stage_o(a_stg), .wr_en_o(a_wr), .wr_cnt_o(a_wcnt),
    .wr_stage_o(a_wstg)
  );

  ntt_stage_ctrl #(.BU_LAT(1), .NUM_STAGES(7)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b),
    .busy_o(b_busy), .done_o(b_done), .len_o(b_len),
    .zeta_start_o(b_zs), .rd_en_o(b_rd), .rd_cnt_o(b_cnt),
    .stage_o(b_stg), .wr_en_o(b_wr), .wr_cnt_o(b_wcnt),
    .wr_stage_o(b_wstg)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd;
    logic       zs;
    logic [7:0] len;
    logic [3:0] cnt;
    logic [2:0] stg;
  } exp_t;

  typedef struct packed {
    int         cyc;
    logic [7:0] len;
    logic       rd;
    logic       zs;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t vt [17];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference schedule: stage s runs 16 cycles from 1 + s*(16+lat)
  function automatic exp_t model(input int c, input int lat);
    exp_t e;
    int p, s, r, dc;
    e = '0;
    e.len = 8'd1;
    dc = 1 + 7 * 16 + 7 * lat;
    if (c < 1 || c > dc) return e;
    e.busy = 1'b1;
    e.stg  = 3'd6;
    if (c == dc) begin
      e.done = 1'b1;
      return e;
    end
    p = 16 + lat;
    s = (c - 1) / p;
    r = (c - 1) % p;
    if (r < 16) begin
      e.rd  = 1'b1;
      e.cnt = 4'(r);
      e.stg = 3'(s);
      e.len = 8'd128 >> s;
      e.zs  = (r == 0);
    end else begin
      e.stg = (s < 6) ? 3'(s + 1) : 3'd6;
    end
    return e;
  endfunction

  task automatic sample(input int lat, output exp_t o, output logic wr,
                        output logic [3:0] wc, output logic [2:0] ws);
    if (lat == 4) begin
      o  = {a_busy, a_done, a_rd, a_zs, a_len, a_cnt, a_stg};
      wr = a_wr; wc = a_wcnt; ws = a_wstg;
    end else begin
      o  = {b_busy, b_done, b_rd, b_zs, b_len, b_cnt, b_stg};
      wr = b_wr; wc = b_wcnt; ws = b_wstg;
    end
  endtask

  task automatic set_start(input int lat, input logic v);
    if (lat == 4) start_a = v;
    else start_b = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_full(input int lat, input int ncyc, input bit hold);
    exp_t e, w, o;
    logic wr;
    logic [3:0] wc;
    logic [2:0] ws;
    int rd_n, wr_n, done_n, done_at;
    rd_n = 0; wr_n = 0; done_n = 0; done_at = -1;
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) tick();
      if (c == 1 && !hold) set_start(lat, 1'b0);
      sample(lat, o, wr, wc, ws);
      e = model(c, lat);
      w = model(c - lat, lat);
      chk("busy", o.busy, e.busy);
      chk("done", o.done, e.done);
      chk("rd_en", o.rd, e.rd);
      chk("zeta_start", o.zs, e.zs);
      chk("len", o.len, e.len);
      if (e.busy) chk("stage", o.stg, e.stg);
      if (e.rd) chk("rd_cnt", o.cnt, e.cnt);
      chk("wr_en", wr, w.rd);
      if (w.rd) begin
        chk("wr_cnt", wc, w.cnt);
        chk("wr_stage", ws, w.stg);
      end
      if (o.rd && wr) chk("hazard_stage", ws, o.stg);
      if (lat == 4) begin
        for (int i = 0; i < 17; i++) begin
          if (vt[i].cyc == c) begin
            chk("vec_len", o.len, vt[i].len);
            chk("vec_rd", o.rd, vt[i].rd);
            chk("vec_zs", o.zs, vt[i].zs);
            chk("vec_done", o.done, vt[i].done);
            chk("vec_busy", o.busy, vt[i].busy);
          end
        end
      end
      if (o.rd === 1'b1) rd_n++;
      if (wr === 1'b1) wr_n++;
      if (o.done === 1'b1) begin
        done_n++;
        done_at = c;
      end
      if (c == 0) set_start(lat, 1'b1);
    end
    chk("rd_total", rd_n, 112);
    chk("wr_total", wr_n, 112);
    chk("done_pulses", done_n, 1);
    chk("done_cycle", done_at, 1 + 7 * 16 + 7 * lat);
  endtask

  initial begin
    vt[0]  = '{0,   8'd1,   1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1,   8'd128, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[2]  = '{2,   8'd128, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[3]  = '{16,  8'd128, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{17,  8'd1,   1'b0, 1'b0, 1'b0, 1'b1};
    vt[5]  = '{20,  8'd1,   1'b0, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{21,  8'd64,  1'b1, 1'b1, 1'b0, 1'b1};
    vt[7]  = '{41,  8'd32,  1'b1, 1'b1, 1'b0, 1'b1};
    vt[8]  = '{61,  8'd16,  1'b1, 1'b1, 1'b0, 1'b1};
    vt[9]  = '{81,  8'd8,   1'b1, 1'b1, 1'b0, 1'b1};
    vt[10] = '{101, 8'd4,   1'b1, 1'b1, 1'b0, 1'b1};
    vt[11] = '{121, 8'd2,   1'b1, 1'b1, 1'b0, 1'b1};
    vt[12] = '{136, 8'd2,   1'b1, 1'b0, 1'b0, 1'b1};
    vt[13] = '{137, 8'd1,   1'b0, 1'b0, 1'b0, 1'b1};
    vt[14] = '{140, 8'd1,   1'b0, 1'b0, 1'b0, 1'b1};
    vt[15] = '{141, 8'd1,   1'b0, 1'b0, 1'b1, 1'b1};
    vt[16] = '{142, 8'd1,   1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    do_reset();
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_len", a_len, 8'd1);
    chk("rst_rd", a_rd, 1'b0);
    chk("rst_wr", a_wr, 1'b0);
    chk("rst_stage", a_stg, 3'd0);
    chk("rst_wr_stage", a_wstg, 3'd0);

    // Default latency full transform
    cyc = 0;
    run_full(4, 145, 1'b0);

    // start held high: one transform, next accepted only from IDLE
    cyc = 0;
    run_full(4, 141, 1'b1);
    tick();
    chk("hold_idle_busy", a_busy, 1'b0);
    chk("hold_idle_rd", a_rd, 1'b0);
    tick();
    chk("hold_rerun_rd", a_rd, 1'b1);
    chk("hold_rerun_len", a_len, 8'd128);
    chk("hold_rerun_zs", a_zs, 1'b1);
    chk("hold_rerun_cnt", a_cnt, 4'd0);
    for (int i = 144; i <= 150; i++) begin
      tick();
      chk("hold_no_done", a_done, 1'b0);
    end
    start_a = 1'b0;

    // Reset mid-transform aborts at once
    do_reset();
    cyc = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    while (cyc < 50) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", a_busy, 1'b0);
    chk("abort_len", a_len, 8'd1);
    chk("abort_rd", a_rd, 1'b0);
    chk("abort_wr", a_wr, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("abort_wr_quiet", a_wr, 1'b0);
      chk("abort_rd_quiet", a_rd, 1'b0);
    end
    cyc = 0;
    run_full(4, 145, 1'b0);

    // Minimum BU latency instance
    cyc = 0;
    run_full(1, 125, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
